// File: rtl/frame_manager_if.sv
// rtl/frame_manager_if.sv - handshake and bus bundle between frame_manager and its neighbours
interface frame_manager_if #(
    parameter int PC_W     = 16,
    parameter int LVA_AW   = 8,
    parameter int CS_DEPTH = 32
);
    localparam int DW = $clog2(CS_DEPTH) + 1;

    logic              invoke;
    logic              ret;
    logic [15:0]       desc_index;
    logic [PC_W-1:0]   pc_in;
    logic [15:0]       data_index;
    logic [31:0]       data_params;
    logic              eval_pop;
    logic              eval_done;
    logic [31:0]       eval_value;
    logic              lva_wr;
    logic [LVA_AW-1:0] lva_addr;
    logic [31:0]       lva_wdata;
    logic              lva_done;
    logic              pc_load;
    logic [PC_W-1:0]   pc_target;
    logic [LVA_AW-1:0] lva_base;
    logic [LVA_AW-1:0] lva_size;
    logic [DW-1:0]     depth;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic [DW-1:0]     hwm;

    modport master (
        output invoke, ret, desc_index, pc_in, data_params, eval_done, eval_value, lva_done,
        input  data_index, eval_pop, lva_wr, lva_addr, lva_wdata, pc_load, pc_target,
               lva_base, lva_size, depth, busy, done, err, hwm
    );

    modport slave (
        input  invoke, ret, desc_index, pc_in, data_params, eval_done, eval_value, lva_done,
        output data_index, eval_pop, lva_wr, lva_addr, lva_wdata, pc_load, pc_target,
               lva_base, lva_size, depth, busy, done, err, hwm
    );
endinterface

// File: rtl/frame_manager.sv
// rtl/frame_manager.sv - method invoke/return frame sequencer with internal call stack
// Optional FRAME_HWM_EN: hwm tracks the call stack depth high-water mark since reset.
module frame_manager #(
    parameter int PC_W     = 16,
    parameter int LVA_AW   = 8,
    parameter int CS_DEPTH = 32,
    parameter int MEM_LAT  = 2,
    parameter int RET_OFS  = 3
) (
    input  logic           clk,
    input  logic           rst,
    frame_manager_if.slave bus
);
    localparam int DW  = $clog2(CS_DEPTH) + 1;
    localparam int IW  = $clog2(CS_DEPTH);
    localparam int CW  = (LVA_AW + 1 > 9) ? LVA_AW + 1 : 9;
    localparam int LCW = $clog2(MEM_LAT + 1);
    localparam int EW  = PC_W + 2 * LVA_AW;
    localparam logic [CW-1:0] LVA_LIM = CW'(1) << LVA_AW;

    typedef enum logic [3:0] {
        S_IDLE, S_DESC, S_LATCH, S_CHECK, S_POP, S_WR, S_PUSH, S_JUMP, S_RPOP
    } state_t;

    state_t            state;
    logic [LCW-1:0]    lat_cnt;
    logic [15:0]       code_r;
    logic [7:0]        argc_r;
    logic [7:0]        sz_r;
    logic [CW-1:0]     nb_r;
    logic [PC_W-1:0]   ret_pc_r;
    logic [EW-1:0]     stack [CS_DEPTH];

    logic [15:0]       data_index_r;
    logic              eval_pop_r;
    logic              lva_wr_r;
    logic [LVA_AW-1:0] lva_addr_r;
    logic [31:0]       lva_wdata_r;
    logic              pc_load_r;
    logic [PC_W-1:0]   pc_target_r;
    logic [LVA_AW-1:0] base_r;
    logic [LVA_AW-1:0] size_r;
    logic [DW-1:0]     depth_r;
    logic              done_r;
    logic [1:0]        err_r;

    // New frame starts right after the caller's frame; bounds checked one bit wider.
    logic [CW-1:0] nb_c;
    logic [CW-1:0] end_c;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] top_idx;
    assign nb_c     = CW'(base_r) + CW'(size_r);
    assign end_c    = nb_r + CW'(sz_r);
    assign push_idx = depth_r[IW-1:0];
    assign top_idx  = IW'(depth_r - DW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            code_r       <= '0;
            argc_r       <= '0;
            sz_r         <= '0;
            nb_r         <= '0;
            ret_pc_r     <= '0;
            data_index_r <= '0;
            eval_pop_r   <= 1'b0;
            lva_wr_r     <= 1'b0;
            lva_addr_r   <= '0;
            lva_wdata_r  <= '0;
            pc_load_r    <= 1'b0;
            pc_target_r  <= '0;
            base_r       <= '0;
            size_r       <= '0;
            depth_r      <= '0;
            done_r       <= 1'b0;
            err_r        <= '0;
        end else begin
            eval_pop_r <= 1'b0;
            lva_wr_r   <= 1'b0;
            pc_load_r  <= 1'b0;
            done_r     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.invoke) begin
                        data_index_r <= bus.desc_index;
                        ret_pc_r     <= bus.pc_in + PC_W'(RET_OFS);
                        lat_cnt      <= '0;
                        state        <= S_DESC;
                    end else if (bus.ret) begin
                        state <= S_RPOP;
                    end
                end
                S_DESC: begin
                    if (lat_cnt == LCW'(MEM_LAT - 1)) state <= S_LATCH;
                    else lat_cnt <= lat_cnt + LCW'(1);
                end
                S_LATCH: begin
                    code_r <= bus.data_params[31:16];
                    argc_r <= bus.data_params[15:8];
                    sz_r   <= bus.data_params[7:0];
                    nb_r   <= nb_c;
                    state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (depth_r == DW'(CS_DEPTH) || end_c > LVA_LIM || argc_r > sz_r) begin
                        err_r[0] <= 1'b1;
                        state    <= S_IDLE;
                    end else if (argc_r == 8'd0) begin
                        state <= S_PUSH;
                    end else begin
                        eval_pop_r <= 1'b1;
                        state      <= S_POP;
                    end
                end
                S_POP: begin
                    // Top of eval stack is the last argument, so fill the frame downwards.
                    if (bus.eval_done) begin
                        lva_addr_r  <= LVA_AW'(nb_r + CW'(argc_r) - CW'(1));
                        lva_wdata_r <= bus.eval_value;
                        lva_wr_r    <= 1'b1;
                        state       <= S_WR;
                    end
                end
                S_WR: begin
                    if (bus.lva_done) begin
                        argc_r <= argc_r - 8'd1;
                        if (argc_r == 8'd1) begin
                            state <= S_PUSH;
                        end else begin
                            eval_pop_r <= 1'b1;
                            state      <= S_POP;
                        end
                    end
                end
                S_PUSH: begin
                    stack[push_idx] <= {ret_pc_r, base_r, size_r};
                    depth_r         <= depth_r + DW'(1);
                    base_r          <= LVA_AW'(nb_r);
                    size_r          <= LVA_AW'(sz_r);
                    pc_target_r     <= PC_W'(code_r);
                    pc_load_r       <= 1'b1;
                    done_r          <= 1'b1;
                    state           <= S_JUMP;
                end
                S_JUMP: begin
                    state <= S_IDLE;
                end
                S_RPOP: begin
                    if (depth_r == '0) begin
                        err_r[1] <= 1'b1;
                    end else begin
                        {pc_target_r, base_r, size_r} <= stack[top_idx];
                        depth_r   <= depth_r - DW'(1);
                        pc_load_r <= 1'b1;
                        done_r    <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FRAME_HWM_EN
    logic [DW-1:0] hwm_r;
    always_ff @(posedge clk) begin
        if (rst) hwm_r <= '0;
        else if (state == S_PUSH && depth_r >= hwm_r) hwm_r <= depth_r + DW'(1);
    end
    assign bus.hwm = hwm_r;
`else
    assign bus.hwm = '0;
`endif

    assign bus.data_index = data_index_r;
    assign bus.eval_pop   = eval_pop_r;
    assign bus.lva_wr     = lva_wr_r;
    assign bus.lva_addr   = lva_addr_r;
    assign bus.lva_wdata  = lva_wdata_r;
    assign bus.pc_load    = pc_load_r;
    assign bus.pc_target  = pc_target_r;
    assign bus.lva_base   = base_r;
    assign bus.lva_size   = size_r;
    assign bus.depth      = depth_r;
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = done_r;
    assign bus.err        = err_r;
endmodule

// File: tb/tb_frame_manager.sv
// tb/tb_frame_manager.sv - self-checking bench for frame_manager against a call-stack model
module tb_frame_manager;
    localparam int PC_W = 16, LVA_AW = 8, CS_DEPTH = 4, MEM_LAT = 2, RET_OFS = 3;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  base;
        logic [7:0]  size;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_manager_if #(.PC_W(PC_W), .LVA_AW(LVA_AW), .CS_DEPTH(CS_DEPTH)) bus ();

    frame_manager #(
        .PC_W(PC_W), .LVA_AW(LVA_AW), .CS_DEPTH(CS_DEPTH), .MEM_LAT(MEM_LAT), .RET_OFS(RET_OFS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0, n_fail = 0;
    int n_pop = 0, n_wr = 0, n_load = 0;
    logic [15:0] last_target = '0;
    bit op_active = 1'b0, eval_hold = 1'b0;

    logic [7:0]  m_base, m_size;
    int          m_depth, m_hwm;
    logic [1:0]  m_err;
    frame_t      m_stack[$];
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] eval_q[$];
    logic [31:0] desc_mem [0:15];
    logic [31:0] lva_mem [0:255];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_base = '0; m_size = '0; m_depth = 0; m_hwm = 0; m_err = '0;
        m_stack.delete(); exp_addr.delete(); exp_data.delete(); eval_q.delete();
    endtask

    // Program memory: data_params follows data_index after MEM_LAT cycles
    initial begin
        logic [15:0] pipe [MEM_LAT];
        bus.data_params = '0;
        for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
        forever begin
            @(posedge clk); #2;
            bus.data_params = desc_mem[pipe[MEM_LAT-1][3:0]];
            for (int i = MEM_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = bus.data_index;
        end
    end

    initial begin
        bit pend = 1'b0;
        bus.eval_done = 1'b0; bus.eval_value = '0;
        forever begin
            @(posedge clk); #2;
            bus.eval_done = 1'b0;
            if (rst) pend = 1'b0;
            else begin
                if (pend && !eval_hold) begin
                    bus.eval_done = 1'b1;
                    if (eval_q.size() > 0) bus.eval_value = eval_q.pop_back();
                    else bus.eval_value = 32'hDEAD_BEEF;
                    pend = 1'b0;
                end
                if (bus.eval_pop) begin n_pop++; pend = 1'b1; end
            end
        end
    end

    initial begin
        bit pend = 1'b0;
        bus.lva_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.lva_done = 1'b0;
            if (rst) pend = 1'b0;
            else begin
                if (pend) begin bus.lva_done = 1'b1; pend = 1'b0; end
                if (bus.lva_wr) begin
                    n_wr++;
                    lva_mem[bus.lva_addr] = bus.lva_wdata;
                    check("lva_wr_expected", exp_addr.size() > 0, 1);
                    if (exp_addr.size() > 0) begin
                        check("lva_addr", bus.lva_addr, exp_addr.pop_front());
                        check("lva_wdata", bus.lva_wdata, exp_data.pop_front());
                    end
                    pend = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("done_with_pc_load", bus.done, bus.pc_load);
            if (bus.pc_load) begin n_load++; last_target = bus.pc_target; end
            if (!bus.busy) begin
                check("idle_eval_pop", bus.eval_pop, 0);
                check("idle_lva_wr", bus.lva_wr, 0);
            end
            if (!op_active) begin
                check("mon_busy", bus.busy, 0);
                check("mon_base", bus.lva_base, m_base);
                check("mon_size", bus.lva_size, m_size);
                check("mon_depth", bus.depth, m_depth);
                check("mon_err", bus.err, m_err);
`ifdef FRAME_HWM_EN
                check("mon_hwm", bus.hwm, m_hwm);
`else
                check("mon_hwm", bus.hwm, 0);
`endif
            end
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.busy && k < 300) begin @(negedge clk); k++; end
        check({name, "_timeout"}, k < 300, 1);
        @(negedge clk);
    endtask

    task automatic do_invoke(input logic [15:0] idx, input logic [15:0] pc, input bit with_ret);
        logic [31:0] d;
        logic [7:0]  argc, sz;
        int nb, loads0, pops0;
        bit ok;
        frame_t f;
        d = desc_mem[idx[3:0]]; argc = d[15:8]; sz = d[7:0];
        nb = m_base + m_size;
        ok = (m_depth < CS_DEPTH) && (nb + sz <= 256) && (argc <= sz);
        if (ok) for (int i = 0; i < argc; i++) begin
            exp_addr.push_back(8'(nb + argc - 1 - i));
            exp_data.push_back(eval_q[eval_q.size() - 1 - i]);
        end
        loads0 = n_load; pops0 = n_pop;
        @(posedge clk); #1;
        op_active = 1'b1; bus.invoke = 1'b1; bus.ret = with_ret; bus.desc_index = idx; bus.pc_in = pc;
        @(posedge clk); #1;
        bus.invoke = 1'b0; bus.ret = 1'b0; bus.desc_index = 16'hFFFF; bus.pc_in = 16'hFFFF;
        wait_idle("invoke");
        check("invoke_pc_loads", n_load - loads0, ok ? 1 : 0);
        check("invoke_pops", n_pop - pops0, ok ? int'(argc) : 0);
        check("invoke_wr_drained", exp_addr.size(), 0);
        if (ok) begin
            check("invoke_pc_target", last_target, d[31:16]);
            f.pc = pc + 16'(RET_OFS); f.base = m_base; f.size = m_size;
            m_stack.push_back(f);
            m_base = 8'(nb); m_size = sz; m_depth++;
            if (m_depth > m_hwm) m_hwm = m_depth;
        end else m_err[0] = 1'b1;
        op_active = 1'b0;
    endtask

    task automatic do_ret();
        bit ok;
        int loads0;
        frame_t f;
        ok = (m_depth > 0); loads0 = n_load;
        @(posedge clk); #1;
        op_active = 1'b1; bus.ret = 1'b1;
        @(posedge clk); #1;
        bus.ret = 1'b0;
        wait_idle("ret");
        check("ret_pc_loads", n_load - loads0, ok ? 1 : 0);
        if (ok) begin
            f = m_stack.pop_back();
            check("ret_pc_target", last_target, f.pc);
            m_base = f.base; m_size = f.size; m_depth--;
        end else m_err[1] = 1'b1;
        op_active = 1'b0;
    endtask

    initial begin
        int pops0, wr0, k;
        desc_mem[0] = {16'h0040, 8'd2, 8'd4};
        desc_mem[1] = {16'h0080, 8'd0, 8'd3};
        desc_mem[2] = {16'h0100, 8'd0, 8'd1};
        desc_mem[3] = {16'h0200, 8'd0, 8'd250};
        desc_mem[4] = {16'h0300, 8'd0, 8'd4};
        desc_mem[5] = {16'h0400, 8'd0, 8'd8};
        desc_mem[6] = {16'h0500, 8'd3, 8'd2};
        desc_mem[7] = {16'h0600, 8'd1, 8'd2};
        for (int i = 8; i < 16; i++) desc_mem[i] = 32'h0F0F_0101;
        bus.invoke = 1'b0; bus.ret = 1'b0; bus.desc_index = '0; bus.pc_in = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_depth", bus.depth, 0);
        check("rst_err", bus.err, 0);
        check("rst_pc_target", bus.pc_target, 0);
        check("rst_data_index", bus.data_index, 0);
        check("rst_base_size", {bus.lva_base, bus.lva_size}, 0);

        // 1: two args, B on top of stack lands at LVA[1]
        eval_q = '{32'h0000_0011, 32'hA0A0_0001, 32'hB0B0_0002};
        do_invoke(16'd0, 16'h0010, 1'b0);
        check("t1_lva1_B", lva_mem[1], 32'hB0B0_0002);
        check("t1_lva0_A", lva_mem[0], 32'hA0A0_0001);
        check("t1_pc_target", last_target, 16'h0040);
        check("t1_base_size_depth", {bus.lva_base, bus.lva_size, 5'(bus.depth)}, {8'd0, 8'd4, 5'd1});

        // 2: nested argc=0 invoke then unwind
        do_invoke(16'd1, 16'h0040, 1'b0);
        check("t2_base", bus.lva_base, 8'd4);
        check("t2_size", bus.lva_size, 8'd3);
        do_ret();
        check("t2_ret_base_size", {bus.lva_base, bus.lva_size}, {8'd0, 8'd4});
        check("t2_ret_pc", last_target, 16'h0043);
        do_ret();
        check("t2_ret2_pc", last_target, 16'h0013);
        check("t2_ret2_depth", bus.depth, 0);

        // 3: fill the call stack, one more invoke overflows
        for (int i = 0; i < 5; i++) do_invoke(16'd2, 16'h0100 + 16'(i * 16), 1'b0);
        check("t3_depth_full", bus.depth, 4);
        check("t3_err", bus.err, 2'b01);
        for (int i = 0; i < 4; i++) do_ret();

        // 4: underflow, then a normal invoke still works
        do_ret();
        check("t4_err", bus.err, 2'b11);
        do_invoke(16'd2, 16'h0200, 1'b0);
        check("t4_depth", bus.depth, 1);
        check("t4_pc_target", last_target, 16'h0100);
        do_ret();

        // 5: invoke and ret together -> invoke only
        eval_q = '{32'h5555_0007};
        do_invoke(16'd7, 16'h0300, 1'b1);
        check("t5_lva0", lva_mem[0], 32'h5555_0007);
        check("t5_depth", bus.depth, 1);

        // 5b: reset while waiting for the eval stack
        eval_hold = 1'b1;
        eval_q = '{32'h1, 32'h2};
        pops0 = n_pop;
        @(posedge clk); #1;
        op_active = 1'b1; bus.invoke = 1'b1; bus.desc_index = 16'd0; bus.pc_in = 16'h0400;
        @(posedge clk); #1;
        bus.invoke = 1'b0;
        k = 0;
        while (n_pop == pops0 && k < 50) begin @(negedge clk); k++; end
        check("t5_pop_issued", n_pop > pops0, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_reset(); op_active = 1'b0; eval_hold = 1'b0;
        pops0 = n_pop; wr0 = n_wr;
        repeat (10) @(negedge clk);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_depth", bus.depth, 0);
        check("t5_rst_no_pop", n_pop - pops0, 0);
        check("t5_rst_no_wr", n_wr - wr0, 0);
        check("t5_rst_err", bus.err, 0);

        // 6: LVA overflow from base 250 size 4, argc > size, then high-water mark
        do_invoke(16'd3, 16'h0500, 1'b0);
        do_invoke(16'd4, 16'h0600, 1'b0);
        check("t6_base", bus.lva_base, 8'd250);
        do_invoke(16'd5, 16'h0700, 1'b0);
        check("t6_err", bus.err, 2'b01);
        check("t6_base_kept", bus.lva_base, 8'd250);
        do_invoke(16'd6, 16'h0710, 1'b0);
        check("t6_argc_depth", bus.depth, 2);
        do_ret(); do_ret();
        for (int i = 0; i < 3; i++) do_invoke(16'd2, 16'h0800 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) do_ret();
        check("t6_depth", bus.depth, 0);
`ifdef FRAME_HWM_EN
        check("t6_hwm", bus.hwm, 3);
`else
        check("t6_hwm", bus.hwm, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule
